usb_fs_in_ep_fifo: RTL

- Application-side IN endpoint. It sits on the opposite end of the usb_fs_pe IN endpoint interface.
- Buffers bytes written by user logic in a local FIFO, packetizes them into packets of up to MAX_PKT bytes, and arbitrates for the IN protocol engine.
- Pushes each packet byte-by-byte and holds off the next packet until the host ACKs.
- Supports explicit flush: short packet or ZLP.

---
 rtl/usb_fs_in_ep_fifo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/usb_fs_in_ep_fifo.sv
// Application-side IN endpoint: buffers user bytes, cuts them into packets of up to
// MAX_PKT bytes, and hands each packet to the IN protocol engine, holding off until ACK.
module usb_fs_in_ep_fifo #(
   parameter int unsigned MAX_PKT    = 64,
   parameter int unsigned FIFO_DEPTH = 128
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            usb_reset,
   input  logic [7:0]                      app_data,
   input  logic                            app_put,
   output logic                            app_free,
   input  logic                            app_flush,
   input  logic                            app_stall,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            in_ep_req,
   input  logic                            in_ep_grant,
   input  logic                            in_ep_data_free,
   output logic                            in_ep_data_put,
   output logic [7:0]                      in_ep_data,
   output logic                            in_ep_data_done,
   output logic                            in_ep_stall,
   input  logic                            in_ep_acked
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned PLW = $clog2(MAX_PKT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_DONE,
      S_WAIT_ACK
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PLW-1:0]   pkt_len_q, pkt_len_d;
   logic [PLW-1:0]   bytes_left_q, bytes_left_d;
   logic             flush_pend_q, flush_pend_d;
   logic             stall_q, stall_d;
   logic [7:0]       mem_q [FIFO_DEPTH];

   logic             push;
   logic             pop;

   assign app_free   = (count_q != CW'(FIFO_DEPTH));
   assign fifo_count = count_q;
   assign push       = app_put && app_free && !usb_reset;
   assign pop        = (state_q == S_FILL) && in_ep_grant && in_ep_data_free
                       && (bytes_left_q != '0);

   // PE-facing strobes; req drops in the same cycle the ACK is seen
   assign in_ep_req       = (state_q != S_IDLE)
                            && !((state_q == S_WAIT_ACK) && in_ep_acked);
   assign in_ep_data_put  = pop;
   assign in_ep_data      = mem_q[rd_ptr_q];
   assign in_ep_data_done = (state_q == S_DONE);
   assign in_ep_stall     = stall_q;

   // Next-state, FIFO bookkeeping and packetizer
   always_comb begin
      state_d      = state_q;
      pkt_len_d    = pkt_len_q;
      bytes_left_d = bytes_left_q;
      flush_pend_d = flush_pend_q | app_flush;
      stall_d      = app_stall;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + CW'(push) - CW'(pop);

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (count_q >= CW'(MAX_PKT)) begin
               pkt_len_d = PLW'(MAX_PKT);
               state_d   = S_REQ;
            end else if (flush_pend_q) begin
               pkt_len_d = PLW'(count_q);
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (in_ep_grant) begin
               bytes_left_d = pkt_len_q;
               state_d      = S_FILL;
            end
         end
         S_FILL: begin
            if (pop) begin
               bytes_left_d = bytes_left_q - PLW'(1);
            end
            if ((bytes_left_q == '0) || (pop && (bytes_left_q == PLW'(1)))) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_WAIT_ACK;
            // A short packet (or ZLP) terminates the transfer the flush asked for
            if (pkt_len_q < PLW'(MAX_PKT)) begin
               flush_pend_d = app_flush;
            end
         end
         S_WAIT_ACK: begin
            if (in_ep_acked) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (usb_reset) begin
         state_d      = S_IDLE;
         pkt_len_d    = '0;
         bytes_left_d = '0;
         flush_pend_d = 1'b0;
         stall_d      = 1'b0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         pkt_len_q    <= '0;
         bytes_left_q <= '0;
         flush_pend_q <= 1'b0;
         stall_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pkt_len_q    <= pkt_len_d;
         bytes_left_q <= bytes_left_d;
         flush_pend_q <= flush_pend_d;
         stall_q      <= stall_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= app_data;
      end
   end

endmodule
